// File: rtl/gray_count_decoder.sv
// Gray-code sample decoder: strobed capture, gray-to-binary conversion, step checking
// and wrap extension into a monotonic count. Two-stage pipeline, enable N -> valid N+2.
module gray_count_decoder #(
  parameter int WIDTH     = 8,
  parameter int EXT_WIDTH = 8,
  parameter int ERR_WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_enable,
  input  logic [WIDTH-1:0]             i_gray_in,
  input  logic                         i_clr_err,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_bin_count,
  output logic [EXT_WIDTH+WIDTH-1:0]   o_ext_count,
  output logic                         o_wrap,
  output logic                         o_step_err,
  output logic [ERR_WIDTH-1:0]         o_err_count
);

  typedef enum logic [0:0] {
    S_PRIME = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]     BIN_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]     BIN_MAX  = {WIDTH{1'b1}};
  localparam logic [ERR_WIDTH-1:0] ERR_ONE  = ERR_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX  = {ERR_WIDTH{1'b1}};
  localparam logic [EXT_WIDTH-1:0] WRAP_ONE = EXT_WIDTH'(1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WIDTH-1:0]       r_g_q;
  logic                   r_s1_v;
  logic [EXT_WIDTH-1:0]   r_wrap_cnt;
  logic [EXT_WIDTH-1:0]   w_wrap_cnt_nxt;
  logic [WIDTH-1:0]       w_b;
  logic [WIDTH-1:0]       w_delta;
  logic                   w_valid_nxt;
  logic                   w_wrap_nxt;
  logic                   w_err_nxt;
  logic [ERR_WIDTH-1:0]   w_err_count_nxt;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Stage-2 classification; o_bin_count doubles as the last accepted reference value.
  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = 1'b0;
    w_wrap_nxt     = 1'b0;
    w_err_nxt      = 1'b0;
    w_wrap_cnt_nxt = r_wrap_cnt;
    w_b            = gray2bin(r_g_q);
    w_delta        = w_b - o_bin_count;
    if (r_s1_v) begin
      w_valid_nxt = 1'b1;
      case (r_state)
        S_PRIME: begin
          w_state_nxt = S_TRACK;
        end
        S_TRACK: begin
          if (w_delta == '0) begin
            w_err_nxt = 1'b0;
          end else if (w_delta == BIN_ONE) begin
            if ((o_bin_count == BIN_MAX) && (w_b == '0)) begin
              w_wrap_nxt     = 1'b1;
              w_wrap_cnt_nxt = r_wrap_cnt + WRAP_ONE;
            end else begin
              w_wrap_nxt = 1'b0;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_PRIME;
        end
      endcase
    end else begin
      w_valid_nxt = 1'b0;
    end

    // Clear takes priority, then the error of the same cycle is counted.
    if (i_clr_err) begin
      w_err_count_nxt = w_err_nxt ? ERR_ONE : '0;
    end else if (w_err_nxt && (o_err_count != ERR_MAX)) begin
      w_err_count_nxt = o_err_count + ERR_ONE;
    end else begin
      w_err_count_nxt = o_err_count;
    end
  end

  // Pipeline, FSM state and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_PRIME;
      r_g_q       <= '0;
      r_s1_v      <= 1'b0;
      r_wrap_cnt  <= '0;
      o_valid     <= 1'b0;
      o_bin_count <= '0;
      o_ext_count <= '0;
      o_wrap      <= 1'b0;
      o_step_err  <= 1'b0;
      o_err_count <= '0;
    end else begin
      r_s1_v <= i_enable;
      if (i_enable) begin
        r_g_q <= i_gray_in;
      end
      r_state     <= w_state_nxt;
      r_wrap_cnt  <= w_wrap_cnt_nxt;
      o_valid     <= w_valid_nxt;
      o_wrap      <= w_wrap_nxt;
      o_step_err  <= w_err_nxt;
      o_err_count <= w_err_count_nxt;
      if (r_s1_v) begin
        o_bin_count <= w_b;
        o_ext_count <= {w_wrap_cnt_nxt, w_b};
      end
    end
  end

endmodule

// File: tb/tb_gray_count_decoder.sv
// Bench for gray_count_decoder: directed scenarios plus random traffic, every cycle
// checked against a cycle-level reference model built from the decoder's rules.
module tb_gray_count_decoder;

  logic        clk = 1'b0;
  logic        reset, enable, clr_err;
  logic [7:0]  gray_in;
  logic        valid, wrap, step_err;
  logic [7:0]  bin_count, err_count;
  logic [15:0] ext_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  bit   m_primed;
  int   m_prev, m_wrap, m_err;
  bit   p_v;
  logic [7:0] p_g;
  int   e_valid, e_wrap, e_serr, e_bin;
  int   wrap_seen, serr_seen;

  always #5 clk = ~clk;

  gray_count_decoder dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_gray_in   (gray_in),
    .i_clr_err   (clr_err),
    .o_valid     (valid),
    .o_bin_count (bin_count),
    .o_ext_count (ext_count),
    .o_wrap      (wrap),
    .o_step_err  (step_err),
    .o_err_count (err_count)
  );

  function automatic int g2b(input int g);
    int r = 0;
    for (int s = 0; s < 8; s++) r = r ^ (g >> s);
    return r & 255;
  endfunction

  function automatic logic [7:0] b2g(input int b);
    int v = b & 255;
    return 8'(v ^ (v >> 1));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict post-edge outputs, drive inputs, sample after the edge, compare.
  task automatic cyc(input bit rst, input bit en, input logic [7:0] g, input bit clr);
    int b, d;
    if (rst) begin
      e_valid = 0; e_wrap = 0; e_serr = 0; e_bin = 0;
      m_primed = 1'b0; m_wrap = 0; m_err = 0; p_v = 1'b0; p_g = 8'h00;
    end else begin
      e_valid = int'(p_v); e_wrap = 0; e_serr = 0;
      if (p_v) begin
        b = g2b(int'(p_g));
        if (!m_primed) begin
          m_primed = 1'b1;
        end else begin
          d = (b - m_prev) & 255;
          if (d == 1) begin
            if (m_prev == 255 && b == 0) begin
              e_wrap = 1;
              m_wrap = (m_wrap + 1) % 256;
            end
          end else if (d != 0) begin
            e_serr = 1;
          end
        end
        m_prev = b;
        e_bin  = b;
      end
      if (clr) m_err = e_serr;
      else if (e_serr == 1 && m_err < 255) m_err = m_err + 1;
      p_v = en;
      p_g = g;
    end
    reset = rst; enable = en; gray_in = g; clr_err = clr;
    @(posedge clk);
    #1;
    chk("valid",     int'(valid),     e_valid);
    chk("wrap",      int'(wrap),      e_wrap);
    chk("step_err",  int'(step_err),  e_serr);
    chk("bin_count", int'(bin_count), e_bin);
    chk("ext_count", int'(ext_count), m_wrap * 256 + e_bin);
    chk("err_count", int'(err_count), m_err);
    wrap_seen += int'(wrap);
    serr_seen += int'(step_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'h5A, 1'b0);
  endtask

  initial begin
    int cnt, lastb, r;
    logic [7:0] g;
    reset = 1'b1; enable = 1'b0; gray_in = 8'h00; clr_err = 1'b0;

    // 1: legal sequence 0,1,2,3
    do_reset();
    chk("reset_valid", int'(valid), 0);
    chk("reset_ext",   int'(ext_count), 0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h01, 1'b0);
    cyc(1'b0, 1'b1, 8'h03, 1'b0);
    cyc(1'b0, 1'b1, 8'h02, 1'b0);
    idle(3);
    chk("t1_bin", int'(bin_count), 3);

    // 2: wrap 0xFF -> 0x00
    do_reset();
    cyc(1'b0, 1'b1, 8'h80, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    idle(3);
    chk("t2_ext", int'(ext_count), 16'h0100);

    // 3: jump 5 -> 9 is an error, then 10 is accepted
    do_reset();
    cyc(1'b0, 1'b1, 8'h07, 1'b0);
    cyc(1'b0, 1'b1, 8'h0D, 1'b0);
    cyc(1'b0, 1'b1, 8'h0F, 1'b0);
    idle(3);
    chk("t3_errcnt", int'(err_count), 1);

    // 4: downward step, saturation, clear, clear+error
    do_reset();
    cyc(1'b0, 1'b1, 8'h05, 1'b0);
    cyc(1'b0, 1'b1, 8'h07, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, b2g((i % 2) ? 8'h40 : 8'h10), 1'b0);
    idle(3);
    chk("t4_sat", int'(err_count), 255);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_clr", int'(err_count), 0);
    cyc(1'b0, 1'b1, b2g(8'h70), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("t4_clr_err", int'(err_count), 1);
    idle(2);

    // 5: reset discards an in-flight sample; next sample primes
    do_reset();
    cyc(1'b0, 1'b1, 8'hC0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 8'h40, 1'b0);
    idle(3);
    chk("t5_bin", int'(bin_count), 8'h7F);

    // 6: free-running gray counter
    do_reset();
    wrap_seen = 0; serr_seen = 0;
    for (int i = 0; i < 600; i++) cyc(1'b0, 1'b1, b2g(i), 1'b0);
    idle(3);
    chk("t6_wraps", wrap_seen, 2);
    chk("t6_errs",  serr_seen, 0);
    chk("t6_ext",   int'(ext_count), 599);

    // random traffic: mostly legal steps, some holds/jumps, clears and resets
    do_reset();
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(99);
      if (r < 70) cnt = (cnt + 1) & 255;
      else if (r < 85) cnt = cnt;
      else cnt = $urandom_range(255);
      g = b2g(cnt);
      cyc(($urandom_range(99) < 1), ($urandom_range(99) < 75), g, ($urandom_range(99) < 4));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
